// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/bypass decisions for D against shadow E/M/W copies; HAZARD_MDU_EN adds mult/div busy sequencing.
// Latency: all outputs combinational from current state and D inputs (zero cycles).
// Backpressure: stall freezes PC and F/D, and inserts a bubble into D/E.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic       D_md_start,
    input  logic       D_md_div,
    input  logic       D_md_use,
    output logic       stall,
    output logic       PC_en,
    output logic       FD_en,
    output logic       DE_clr,
    output logic [1:0] fwd_rs,
    output logic [1:0] fwd_rt,
    output logic       md_busy
);

    logic [4:0] E_A3, M_A3, W_A3;
    logic [1:0] E_Tnew, M_Tnew;
    logic       rs_haz, rt_haz, md_haz;

    function automatic logic reg_hazard(
        input logic [4:0] r, input logic [1:0] tuse,
        input logic [4:0] e_a3, input logic [1:0] e_tnew,
        input logic [4:0] m_a3, input logic [1:0] m_tnew
    );
        return (r != 5'd0) &&
               (((e_a3 == r) && (e_tnew > tuse)) || ((m_a3 == r) && (m_tnew > tuse)));
    endfunction

    // The youngest matching producer decides; a match still in flight blocks older stages.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] e_a3, input logic [1:0] e_tnew,
        input logic [4:0] m_a3, input logic [1:0] m_tnew,
        input logic [4:0] w_a3
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (r == 5'd0)       sel = 2'd0;
        else if (e_a3 == r)  sel = (e_tnew == 2'd0) ? 2'd1 : 2'd0;
        else if (m_a3 == r)  sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (w_a3 == r)  sel = 2'd3;
        return sel;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_A3   <= 5'd0;
            E_Tnew <= 2'd0;
            M_A3   <= 5'd0;
            M_Tnew <= 2'd0;
            W_A3   <= 5'd0;
        end else begin
            E_A3   <= stall ? 5'd0 : D_A3;
            E_Tnew <= stall ? 2'd0 : D_Tnew;
            M_A3   <= E_A3;
            M_Tnew <= (E_Tnew != 2'd0) ? E_Tnew - 2'd1 : 2'd0;
            W_A3   <= M_A3;
        end
    end

`ifdef HAZARD_MDU_EN
    logic       E_start, E_div;
    logic [3:0] md_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_start <= 1'b0;
            E_div   <= 1'b0;
            md_cnt  <= 4'd0;
        end else begin
            E_start <= ~stall & D_md_start;
            E_div   <= ~stall & D_md_div;
            if (E_start)
                md_cnt <= E_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end

    assign md_busy = E_start | (md_cnt != 4'd0);
    assign md_haz  = D_md_use & md_busy;
`else
    logic unused_md;
    assign unused_md = ^{D_md_start, D_md_div, D_md_use};
    assign md_busy   = 1'b0;
    assign md_haz    = 1'b0;
`endif

    assign rs_haz = reg_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
    assign rt_haz = reg_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
    assign stall  = rs_haz | rt_haz | md_haz;
    assign PC_en  = ~stall;
    assign FD_en  = ~stall;
    assign DE_clr = stall;
    assign fwd_rs = fwd_sel(D_rs, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);
    assign fwd_rt = fwd_sel(D_rt, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against an in-flight instruction model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       D_md_start, D_md_div, D_md_use;
    logic       stall, PC_en, FD_en, DE_clr, md_busy;
    logic [1:0] fwd_rs, fwd_rt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_A3(D_A3), .D_Tnew(D_Tnew),
        .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
        .stall(stall), .PC_en(PC_en), .FD_en(FD_en), .DE_clr(DE_clr),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // Model: instructions in flight indexed by age past D (0=E, 1=M, 2=W), each with its Tnew at E entry.
    logic [4:0] m_a3 [3];
    int         m_tn [3];
    int         md_age, md_len;

    function automatic int stage_tnew(int i);
        return (m_tn[i] - i > 0) ? m_tn[i] - i : 0;
    endfunction

    function automatic bit m_haz(logic [4:0] r, logic [1:0] tuse);
        if (r == 0) return 0;
        for (int i = 0; i < 2; i++)
            if (m_a3[i] == r && stage_tnew(i) > int'(tuse)) return 1;
        return 0;
    endfunction

    function automatic int m_fwd(logic [4:0] r);
        if (r == 0) return 0;
        for (int i = 0; i < 3; i++)
            if (m_a3[i] == r) return (stage_tnew(i) == 0) ? i + 1 : 0;
        return 0;
    endfunction

    function automatic bit m_busy();
`ifdef HAZARD_MDU_EN
        return md_age <= md_len;
`else
        return 0;
`endif
    endfunction

    function automatic bit m_stall();
        return m_haz(D_rs, D_Tuse_rs) || m_haz(D_rt, D_Tuse_rt) || (D_md_use && m_busy());
    endfunction

    task automatic m_update(bit st);
        m_a3[2] = m_a3[1]; m_tn[2] = m_tn[1];
        m_a3[1] = m_a3[0]; m_tn[1] = m_tn[0];
        m_a3[0] = st ? 5'd0 : D_A3;
        m_tn[0] = st ? 0 : int'(D_Tnew);
        if (!st && D_md_start) begin
            md_age = 0;
            md_len = D_md_div ? 10 : 5;
        end else if (md_age < 1000) begin
            md_age++;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_a3[i] = 5'd0;
            m_tn[i] = 0;
        end
        md_age = 1000;
        md_len = 0;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tur,
                         input logic [1:0] tut, input logic [4:0] a3, input logic [1:0] tnew,
                         input logic start, input logic dv, input logic use_md);
        D_rs = rs; D_rt = rt; D_Tuse_rs = tur; D_Tuse_rt = tut;
        D_A3 = a3; D_Tnew = tnew; D_md_start = start; D_md_div = dv; D_md_use = use_md;
    endtask

    task automatic set_idle();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_rand();
        logic st;
        st = ($urandom_range(0, 15) == 0);
        set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
              st, 1'($urandom_range(0, 1)), st | ($urandom_range(0, 5) == 0));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_rand();
            @(negedge clk);
            total++;
            if (stall !== 1'b0 || PC_en !== 1'b1 || FD_en !== 1'b1 || DE_clr !== 1'b0 ||
                fwd_rs !== 2'd0 || fwd_rt !== 2'd0 || md_busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: stall=%b pc_en=%b fd_en=%b de_clr=%b fwd_rs=%0d fwd_rt=%0d busy=%b want 0 1 1 0 0 0 0",
                         stall, PC_en, FD_en, DE_clr, fwd_rs, fwd_rt, md_busy);
            end
        end
        reset = 1'b1;
        m_reset();
        #1;
        total++;
        if (stall !== 1'b0 || PC_en !== 1'b1 || fwd_rs !== 2'd0 || md_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: stall=%b pc_en=%b fwd_rs=%0d busy=%b want 0 1 0 0",
                     stall, PC_en, fwd_rs, md_busy);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        int stalls;
        do_reset();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);  // lw $8
        next_cycle();
        set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0); // addu $10, $8, $0
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            total++;
            if (DE_clr !== 1'b1 || PC_en !== 1'b0 || FD_en !== 1'b0) begin
                bad++;
                $display("FAIL load_use_ctl: de_clr=%b pc_en=%b fd_en=%b want 1 0 0", DE_clr, PC_en, FD_en);
            end
            next_cycle();
        end
        total++;
        if (stalls != 1) begin
            bad++;
            $display("FAIL load_use_stalls: got %0d cycles want 1", stalls);
        end
        total++;
        if (fwd_rs !== 2'd0) begin
            bad++;
            $display("FAIL load_use_m_sel: fwd_rs=%0d want 0", fwd_rs);
        end
        next_cycle();
        set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (fwd_rs !== 2'd3 || stall !== 1'b0) begin
            bad++;
            $display("FAIL load_use_w_fwd: fwd_rs=%0d stall=%b want 3 0", fwd_rs, stall);
        end
        next_cycle();
    endtask

    task automatic test_branch_fwd();
        do_reset();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);  // addu $9
        next_cycle();
        set_d(5'd9, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);  // beq $9, $9
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL branch_stall: stall=%b want 1", stall);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_rs !== 2'd2 || fwd_rt !== 2'd2) begin
            bad++;
            $display("FAIL branch_fwd: stall=%b fwd_rs=%0d fwd_rt=%0d want 0 2 2", stall, fwd_rs, fwd_rt);
        end
        next_cycle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin
                bad++;
                $display("FAIL zero_reg: stall=%b fwd_rs=%0d fwd_rt=%0d want 0 0 0", stall, fwd_rs, fwd_rt);
            end
            next_cycle();
        end
    endtask

`ifdef HAZARD_MDU_EN
    task automatic test_mdu(input bit is_div, input int want);
        int stalls, busies;
        bit done;
        do_reset();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, is_div, 1'b1);
        next_cycle();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1);  // mflo $2
        stalls = 0; busies = 0; done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (md_busy) busies++;
            if (!stall) begin
                done = 1;
                break;
            end
            stalls++;
            next_cycle();
        end
        total++;
        if (!done || stalls != want || busies != want || md_busy !== 1'b0) begin
            bad++;
            $display("FAIL mdu_%s: done=%0d stalls=%0d busy_cycles=%0d busy_now=%b want %0d %0d 0",
                     is_div ? "div" : "mult", done, stalls, busies, md_busy, want, want);
        end
        next_cycle();
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL async_pre_stall: stall=%b want 1", stall);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || PC_en !== 1'b1) begin
            bad++;
            $display("FAIL async_stall_drop: stall=%b pc_en=%b want 0 1", stall, PC_en);
        end
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        next_cycle();
`ifdef HAZARD_MDU_EN
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);  // div
        next_cycle();
        set_idle();
        repeat (7) next_cycle();
        @(negedge clk);
        total++;
        if (md_busy !== 1'b1) begin
            bad++;
            $display("FAIL async_pre_busy: md_busy=%b want 1", md_busy);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (md_busy !== 1'b0) begin
            bad++;
            $display("FAIL async_busy_drop: md_busy=%b want 0", md_busy);
        end
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            total++;
            if (md_busy !== 1'b0) begin
                bad++;
                $display("FAIL async_busy_after: cycle %0d md_busy=%b want 0", i, md_busy);
            end
        end
        next_cycle();
`endif
    endtask

    task automatic test_random();
        bit es;
        int ef_rs, ef_rt;
        bit eb;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            set_rand();
            @(negedge clk);
            es = m_stall();
            ef_rs = m_fwd(D_rs);
            ef_rt = m_fwd(D_rt);
            eb = m_busy();
            total++;
            if (stall !== es || PC_en !== !es || FD_en !== !es || DE_clr !== es) begin
                bad++;
                $display("FAIL rand_stall[%0d]: stall=%b pc_en=%b fd_en=%b de_clr=%b want stall=%b",
                         i, stall, PC_en, FD_en, DE_clr, es);
            end
            total++;
            if (int'(fwd_rs) != ef_rs || int'(fwd_rt) != ef_rt) begin
                bad++;
                $display("FAIL rand_fwd[%0d]: fwd_rs=%0d fwd_rt=%0d want %0d %0d", i, fwd_rs, fwd_rt, ef_rs, ef_rt);
            end
            total++;
            if (md_busy !== eb) begin
                bad++;
                $display("FAIL rand_busy[%0d]: md_busy=%b want %b", i, md_busy, eb);
            end
            m_update(es);
            next_cycle();
        end
    endtask

    initial begin
        set_idle();
        m_reset();
        test_reset();
        test_load_use();
        test_branch_fwd();
        test_zero_reg();
`ifdef HAZARD_MDU_EN
        test_mdu(1'b1, 11);
        test_mdu(1'b0, 6);
`endif
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
